// File: rtl/mts_sysref_qualifier.sv
// SYSREF qualifier: detects rising edges of the PL SYSREF, measures its period,
// declares lock after a run of consistent periods and captures an armed edge.
module mts_sysref_qualifier #(
    parameter int PERIOD_W   = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 1
) (
    input  logic                pl_clk,
    input  logic                rst,
    input  logic                sysref_in,
    input  logic                enable,
    input  logic                arm,
    output logic                sysref_pulse,
    output logic                capture_pulse,
    output logic                capture_done,
    output logic                locked,
    output logic [PERIOD_W-1:0] period,
    output logic                unlock_pulse,
    output logic [7:0]          err_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W:0]   TOL_V   = (PERIOD_W+1)'(TOL);
    localparam logic [3:0]          LOCK_V  = 4'(LOCK_COUNT);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] cnt_nxt_s;
    logic [3:0]          match_cnt_r;
    logic [3:0]          match_cnt_nxt_s;
    logic                ref_valid_r;
    logic                ref_valid_nxt_s;
    logic [PERIOD_W-1:0] ref_period_r;
    logic [PERIOD_W-1:0] ref_period_nxt_s;
    logic                prev_r;
    logic                armed_r;
    logic                armed_nxt_s;
    logic                capture_done_r;
    logic                capture_done_nxt_s;
    logic [7:0]          err_cnt_r;
    logic [7:0]          err_cnt_nxt_s;
    logic                sysref_pulse_r;
    logic                capture_pulse_r;
    logic                unlock_pulse_r;
    logic                locked_r;

    logic                edge_s;
    logic [PERIOD_W:0]   meas_s;
    logic [PERIOD_W:0]   ref_ext_s;
    logic [PERIOD_W:0]   diff_s;
    logic                match_s;
    logic                timeout_s;
    logic                err_inc_s;
    logic                unlock_s;
    logic                capture_s;

    assign sysref_pulse  = sysref_pulse_r;
    assign capture_pulse = capture_pulse_r;
    assign capture_done  = capture_done_r;
    assign locked        = locked_r;
    assign period        = ref_period_r;
    assign unlock_pulse  = unlock_pulse_r;
    assign err_cnt       = err_cnt_r;

    // Edge detection and period comparison against the stored reference.
    always_comb begin
        edge_s    = enable & sysref_in & ~prev_r;
        meas_s    = {1'b0, cnt_r} + {{PERIOD_W{1'b0}}, 1'b1};
        ref_ext_s = {1'b0, ref_period_r};
        if (meas_s >= ref_ext_s) begin
            diff_s = meas_s - ref_ext_s;
        end else begin
            diff_s = ref_ext_s - meas_s;
        end
        match_s   = ref_valid_r && (diff_s <= TOL_V);
        timeout_s = (state_r != ST_IDLE) && (cnt_r == CNT_MAX);
    end

    // Acquisition FSM: next state, reference tracking and event flags.
    always_comb begin
        state_nxt_s      = state_r;
        ref_valid_nxt_s  = ref_valid_r;
        ref_period_nxt_s = ref_period_r;
        match_cnt_nxt_s  = match_cnt_r;
        err_inc_s        = 1'b0;
        unlock_s         = 1'b0;
        capture_s        = 1'b0;
        if (!enable) begin
            state_nxt_s     = ST_IDLE;
            ref_valid_nxt_s = 1'b0;
            match_cnt_nxt_s = 4'd0;
        end else if (edge_s) begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s     = ST_MEASURE;
                    ref_valid_nxt_s = 1'b0;
                end
                ST_MEASURE: begin
                    if (!ref_valid_r) begin
                        ref_period_nxt_s = meas_s[PERIOD_W-1:0];
                        ref_valid_nxt_s  = 1'b1;
                        match_cnt_nxt_s  = 4'd0;
                    end else if (match_s) begin
                        match_cnt_nxt_s = match_cnt_r + 4'd1;
                        if ((match_cnt_r + 4'd1) >= LOCK_V) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_MEASURE;
                        end
                    end else begin
                        ref_period_nxt_s = meas_s[PERIOD_W-1:0];
                        match_cnt_nxt_s  = 4'd0;
                        err_inc_s        = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        capture_s = armed_r;
                    end else begin
                        state_nxt_s      = ST_MEASURE;
                        ref_period_nxt_s = meas_s[PERIOD_W-1:0];
                        match_cnt_nxt_s  = 4'd0;
                        err_inc_s        = 1'b1;
                        unlock_s         = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    ref_valid_nxt_s = 1'b0;
                    match_cnt_nxt_s = 4'd0;
                end
            endcase
        end else if (timeout_s) begin
            // SYSREF vanished: fall back to IDLE and wait for a fresh first edge.
            state_nxt_s     = ST_IDLE;
            ref_valid_nxt_s = 1'b0;
            match_cnt_nxt_s = 4'd0;
            err_inc_s       = 1'b1;
            unlock_s        = (state_r == ST_LOCKED);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Period counter, error counter and arm/capture bookkeeping.
    always_comb begin
        if (!enable || edge_s) begin
            cnt_nxt_s = {PERIOD_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (err_inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end

        // armed_r is the pre-arm value, so an edge coincident with arm cannot capture.
        if (capture_s) begin
            armed_nxt_s        = 1'b0;
            capture_done_nxt_s = 1'b1;
        end else if (arm && !armed_r) begin
            armed_nxt_s        = 1'b1;
            capture_done_nxt_s = 1'b0;
        end else begin
            armed_nxt_s        = armed_r;
            capture_done_nxt_s = capture_done_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {PERIOD_W{1'b0}};
            match_cnt_r     <= 4'd0;
            ref_valid_r     <= 1'b0;
            ref_period_r    <= {PERIOD_W{1'b0}};
            prev_r          <= 1'b1;
            armed_r         <= 1'b0;
            capture_done_r  <= 1'b0;
            err_cnt_r       <= 8'd0;
            sysref_pulse_r  <= 1'b0;
            capture_pulse_r <= 1'b0;
            unlock_pulse_r  <= 1'b0;
            locked_r        <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            match_cnt_r     <= match_cnt_nxt_s;
            ref_valid_r     <= ref_valid_nxt_s;
            ref_period_r    <= ref_period_nxt_s;
            prev_r          <= sysref_in;
            armed_r         <= armed_nxt_s;
            capture_done_r  <= capture_done_nxt_s;
            err_cnt_r       <= err_cnt_nxt_s;
            sysref_pulse_r  <= edge_s;
            capture_pulse_r <= capture_s;
            unlock_pulse_r  <= unlock_s;
            locked_r        <= (state_nxt_s == ST_LOCKED);
        end
    end

endmodule

// File: tb/tb_mts_sysref_qualifier.sv
// Randomized scoreboard bench for mts_sysref_qualifier: an event-level model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_mts_sysref_qualifier;

    localparam int PW   = 16;
    localparam int LC   = 4;
    localparam int TL   = 1;
    localparam int MAXC = (1 << PW) - 1;

    logic          pl_clk = 1'b0;
    logic          rst = 1'b1;
    logic          sysref_in = 1'b0;
    logic          enable = 1'b0;
    logic          arm = 1'b0;
    logic          sysref_pulse;
    logic          capture_pulse;
    logic          capture_done;
    logic          locked;
    logic [PW-1:0] period;
    logic          unlock_pulse;
    logic [7:0]    err_cnt;

    always #5 pl_clk = ~pl_clk;

    mts_sysref_qualifier #(.PERIOD_W(PW), .LOCK_COUNT(LC), .TOL(TL)) dut (
        .pl_clk        (pl_clk),
        .rst           (rst),
        .sysref_in     (sysref_in),
        .enable        (enable),
        .arm           (arm),
        .sysref_pulse  (sysref_pulse),
        .capture_pulse (capture_pulse),
        .capture_done  (capture_done),
        .locked        (locked),
        .period        (period),
        .unlock_pulse  (unlock_pulse),
        .err_cnt       (err_cnt)
    );

    typedef struct packed {
        logic          sp;
        logic          cp;
        logic          cd;
        logic          lk;
        logic [PW-1:0] per;
        logic          up;
        logic [7:0]    err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model: timestamps of the last edge instead of a counter.
    int m_state;     // 0 idle, 1 measure, 2 locked
    int m_ref, m_valid, m_matches, m_err, m_last, m_prev, m_armed, m_done;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic void bump_err();
        if (m_err < 255) m_err = m_err + 1;
    endfunction

    task automatic step(input logic sr, input logic en, input logic ar, input logic rs);
        exp_t e;
        int   meas;
        bit   edge_seen;
        bit   cap;
        @(negedge pl_clk);
        rst = rs; sysref_in = sr; enable = en; arm = ar;
        e = '0;
        cap = 1'b0;
        if (rs) begin
            m_state = 0; m_ref = 0; m_valid = 0; m_matches = 0; m_err = 0;
            m_prev = 1; m_armed = 0; m_done = 0; m_last = cyc;
        end else begin
            edge_seen = en && sr && (m_prev == 0);
            m_prev = sr;
            meas = cyc - m_last;
            if (meas > MAXC + 1) meas = MAXC + 1;
            if (!en) begin
                m_state = 0; m_valid = 0; m_matches = 0; m_last = cyc;
            end else if (edge_seen) begin
                e.sp = 1'b1;
                m_last = cyc;
                if (m_state == 0) begin
                    m_state = 1; m_valid = 0;
                end else if (m_state == 1) begin
                    if (!m_valid) begin
                        m_ref = meas & MAXC; m_valid = 1; m_matches = 0;
                    end else if (absdiff(meas, m_ref) <= TL) begin
                        m_matches = m_matches + 1;
                        if (m_matches >= LC) m_state = 2;
                    end else begin
                        m_ref = meas & MAXC; m_matches = 0; bump_err();
                    end
                end else begin
                    if (absdiff(meas, m_ref) <= TL) begin
                        cap = (m_armed != 0);
                    end else begin
                        m_state = 1; m_ref = meas & MAXC; m_matches = 0;
                        bump_err(); e.up = 1'b1;
                    end
                end
            end else if (m_state != 0 && (cyc - m_last) > MAXC) begin
                e.up = (m_state == 2);
                m_state = 0; m_valid = 0; m_matches = 0;
                bump_err();
            end
            if (cap) begin
                m_armed = 0; m_done = 1; e.cp = 1'b1;
            end else if (ar && !m_armed) begin
                m_armed = 1; m_done = 0;
            end
        end
        e.lk  = (m_state == 2);
        e.per = m_ref[PW-1:0];
        e.err = m_err[7:0];
        e.cd  = m_done[0];
        exp_q.push_back(e);
        cyc++;
    endtask

    // One SYSREF period: high for hi cycles, arm pulsed at offset arm_off (-1: none).
    task automatic sysref_period(input int p, input int hi, input int arm_off);
        for (int i = 0; i < p; i++) begin
            step((i < hi), 1'b1, (i == arm_off), 1'b0);
        end
    endtask

    // Monitor: compare every presented output cycle with the queued prediction.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge pl_clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{sysref_pulse, capture_pulse, capture_done, locked, period, unlock_pulse, err_cnt};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    if (miscompares <= 20)
                        $display("FAIL outputs @%0t: got sp=%0b cp=%0b cd=%0b lk=%0b per=%0d up=%0b err=%0d, expected sp=%0b cp=%0b cd=%0b lk=%0b per=%0d up=%0b err=%0d",
                                 $time, got.sp, got.cp, got.cd, got.lk, got.per, got.up, got.err,
                                 e.sp, e.cp, e.cd, e.lk, e.per, e.up, e.err);
                end
            end
        end
    end

    initial begin
        int p, hi, ao;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        // Lock at 64, a tolerated 65, an unlocking 66, then relock.
        repeat (8) sysref_period(64, 8, -1);
        sysref_period(65, 8, -1);
        sysref_period(66, 8, -1);
        repeat (7) sysref_period(64, 8, -1);
        // Arm 10 cycles before an edge, then arm coincident with an edge.
        sysref_period(64, 8, 54);
        repeat (2) sysref_period(64, 8, -1);
        sysref_period(64, 8, 0);
        repeat (3) sysref_period(64, 8, -1);
        // Randomized periods, pulse widths and arm points.
        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(62, 66);
            hi = $urandom_range(1, 10);
            ao = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p - 1)) : -1;
            sysref_period(p, hi, ao);
        end
        // Enable drop mid-stream, then reacquire.
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8) sysref_period(64, 8, -1);
        // Reset while locked with SYSREF held high; outputs must clear at once.
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({sysref_pulse, capture_pulse, capture_done, locked, period, unlock_pulse, err_cnt} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got sp=%0b cp=%0b cd=%0b lk=%0b per=%0d up=%0b err=%0d, expected all zero",
                     sysref_pulse, capture_pulse, capture_done, locked, period, unlock_pulse, err_cnt);
        end
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) sysref_period(64, 8, -1);
        // SYSREF stops: timeout after the counter saturates, then relock.
        repeat (MAXC + 40) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) sysref_period(64, 8, 20);
        // Alternating periods mismatch on every edge and drive err_cnt to saturation.
        repeat (140) begin
            sysref_period(5, 2, -1);
            sysref_period(9, 2, -1);
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge pl_clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mts_sysref_qualifier.md
MTS_SYSREF_QUALIFIER -- requirements
Module: mts_sysref_qualifier

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16: width of the SYSREF period counter and period output.
REQ-002 SHALL have parameter LOCK_COUNT, default 4: number of consecutive matching periods needed to declare lock (legal 1..15).
REQ-003 SHALL have parameter TOL, default 1: allowed absolute period deviation, in pl_clk cycles, that still counts as a match.
REQ-004 SHALL have port pl_clk, input, 1: the block's only clock, the PL/user clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port sysref_in, input, 1: PL SYSREF already registered into the pl_clk domain by the upstream sync stage.
REQ-007 SHALL have port enable, input, 1: synchronous qualifier enable.
REQ-008 SHALL have port arm, input, 1: single-cycle request to capture the next qualified edge.
REQ-009 SHALL have port sysref_pulse, output, 1: one-cycle pulse for each detected rising edge.
REQ-010 SHALL have port capture_pulse, output, 1: one-cycle pulse on the armed, qualified edge.
REQ-011 SHALL have port capture_done, output, 1: sticky flag, set by a capture.
REQ-012 SHALL have port locked, output, 1: high while the FSM is in LOCKED.
REQ-013 SHALL have port period, output, PERIOD_W: reference period in cycles.
REQ-014 SHALL have port unlock_pulse, output, 1: one-cycle pulse on leaving LOCKED.
REQ-015 SHALL have port err_cnt, output, 8: saturating count of period mismatches and timeouts.

Function
REQ-016 SHALL detect an edge in cycle t when sysref_in=1 and the previous-cycle sample=0; the previous-sample register resets to 1, so a SYSREF held high through reset gives no edge.
REQ-017 SHALL assert sysref_pulse in cycle t+1 for each edge at cycle t, whatever the state, while enable=1.
REQ-018 SHALL run a cycle counter cnt: cleared to 0 on an edge cycle, otherwise incremented, saturating at 2^PERIOD_W-1.
REQ-019 SHALL compute the measured period at an edge as cnt+1, so edges at t and t+P give P.
REQ-020 SHALL implement FSM states IDLE, MEASURE and LOCKED, plus a ref_valid flag, a ref_period register and a match_cnt counter.
REQ-021 In IDLE, the first edge SHALL move the FSM to MEASURE with ref_valid=0 and no period recorded.
REQ-022 In MEASURE, an edge with ref_valid=0 SHALL load ref_period with the measured period, set ref_valid=1 and set match_cnt=0.
REQ-023 In MEASURE, an edge with |measured-ref_period|<=TOL SHALL increment match_cnt; when match_cnt reaches LOCK_COUNT the FSM SHALL enter LOCKED.
REQ-024 In MEASURE, an edge with a mismatch SHALL reload ref_period with the measured period, clear match_cnt and increment err_cnt; the FSM stays in MEASURE.
REQ-025 In LOCKED, a matching edge SHALL change no state and SHALL NOT update ref_period.
REQ-026 In LOCKED, a mismatching edge SHALL move the FSM to MEASURE, reload ref_period, clear match_cnt, increment err_cnt and pulse unlock_pulse in the next cycle.
REQ-027 In MEASURE or LOCKED, cnt reaching saturation SHALL be a timeout: the FSM goes to IDLE, ref_valid is cleared, err_cnt increments, and unlock_pulse fires if the FSM was in LOCKED.
REQ-028 enable=0 SHALL force the FSM to IDLE, clear ref_valid, match_cnt and cnt, and suppress all pulses; err_cnt, period and capture_done SHALL be held.
REQ-029 err_cnt SHALL saturate at 255.
REQ-030 locked, period and all pulse outputs SHALL be registered; locked SHALL rise in cycle t+1 after the locking edge at cycle t.
REQ-031 arm SHALL set armed and clear capture_done; the edge that captures SHALL be strictly after the arm cycle, so an edge in the same cycle as arm is ignored for capture.
REQ-032 arm while armed SHALL have no effect.
REQ-033 A matching edge in LOCKED with armed=1 SHALL give capture_pulse in cycle t+1 (coincident with sysref_pulse), clear armed and set capture_done.
REQ-034 armed SHALL persist across unlock and relock; no capture SHALL occur outside LOCKED or on a mismatching edge.

Reset
REQ-035 rst=1 SHALL asynchronously force: FSM=IDLE, cnt=0, match_cnt=0, ref_valid=0, previous sample=1, armed=0.
REQ-036 rst=1 SHALL asynchronously force all outputs to 0: sysref_pulse, capture_pulse, capture_done, locked, period, unlock_pulse, err_cnt.
REQ-037 Reset deassertion mid-stream SHALL restart acquisition from IDLE; the first edge after reset SHALL NOT be counted as a period.

Verification
REQ-038 Defaults, SYSREF period 64 starting from reset -> edges 1..6 produce sysref_pulse; locked rises 1 cycle after edge 6 (first edge, ref edge, then 4 matches); period=64; err_cnt=0.
REQ-039 Locked at period 64, then one period of 66 -> unlock_pulse, locked=0, err_cnt=1, period=66; a period of 65 is a match (TOL=1) and causes no unlock.
REQ-040 Locked, arm pulsed at cycle a, next edge at a+10 -> capture_pulse at a+11 together with sysref_pulse; capture_done=1; later edges give no capture_pulse.
REQ-041 arm in the same cycle as an edge -> no capture on that edge; capture on the following edge, 64 cycles later.
REQ-042 Locked, then sysref_in stops -> after 2^16-1 cycles, locked=0, unlock_pulse, err_cnt increments, FSM in IDLE; re-applied SYSREF relocks after 6 edges.
REQ-043 rst asserted mid-lock with sysref_in held high -> all outputs 0 immediately; after release, no sysref_pulse until the next genuine rising edge.
